// File: rtl/pid_pkg.sv
// Shared types and constants for the PID loop sequencer.
//   seq_state_e : 3-bit sequencer state encoding (also exported on state_out)
//   OVR_W       : width of the saturating overrun counter
//   sat_inc()   : saturating increment for the overrun counter
package pid_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OVR_W   = 8;
  localparam logic [OVR_W-1:0] OVR_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_SENSE_REQ  = 3'd1,
    ST_SENSE_WAIT = 3'd2,
    ST_PID_REQ    = 3'd3,
    ST_PID_WAIT   = 3'd4,
    ST_UPDATE     = 3'd5
  } seq_state_e;

  // Increment that sticks at the maximum value
  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == OVR_MAX) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/pid_loop_sequencer_if.sv
// Handshake/status bundle between the PID loop sequencer and its peers.
//   master : sequencer side (drives starts, update strobe and status)
//   slave  : peer side (drives enable/clear and the done pulses)
interface pid_loop_sequencer_if;
  import pid_pkg::*;

  logic               enable_in;
  logic               clear_in;
  logic               sensor_done;
  logic               pid_done;
  logic               sensor_start;
  logic               pid_start;
  logic               pwm_update;
  logic               busy;
  logic [OVR_W-1:0]   overrun_cnt;
  logic               timeout_flag;
  logic [STATE_W-1:0] state_out;

  modport master (
    input  enable_in, clear_in, sensor_done, pid_done,
    output sensor_start, pid_start, pwm_update, busy,
           overrun_cnt, timeout_flag, state_out
  );

  modport slave (
    output enable_in, clear_in, sensor_done, pid_done,
    input  sensor_start, pid_start, pwm_update, busy,
           overrun_cnt, timeout_flag, state_out
  );

endinterface

// File: rtl/clk_enable.sv
// Free-running clock-enable generator: tick_o pulses for one cycle every
// DIVISOR+1 cycles; the first pulse appears DIVISOR+1 cycles after reset.
//   clk_in   : clock
//   reset_in : asynchronous active-high reset
//   tick_o   : registered one-cycle tick
module clk_enable #(
  parameter int unsigned DIVISOR = 1249999
) (
  input  logic clk_in,
  input  logic reset_in,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIVISOR > 0) ? $clog2(DIVISOR + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             wrap_c;

  assign wrap_c = (cnt_q == CNT_W'(DIVISOR));
  assign cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);

  // Tick is registered from the wrap so it lands one cycle after the terminal count
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap_c;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pid_loop_sequencer.sv
// Control-loop sequencer: on each enabled tick runs
// sense request -> wait sensor -> PID request -> wait PID -> PWM update.
// Ticks arriving mid-sequence are dropped and counted (saturating).
// Optional feature macro: SEQ_TIMEOUT_EN (bounded waits + sticky timeout_flag).
//   clk_in   : system clock
//   reset_in : asynchronous active-high reset
//   seq_if   : handshake/status bundle (master modport)
module pid_loop_sequencer
  import pid_pkg::*;
#(
  parameter int unsigned DIVISOR        = 1249999,
  parameter int unsigned TIMEOUT_CYCLES = 125000
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  pid_loop_sequencer_if.master  seq_if
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic tick;

  clk_enable #(.DIVISOR(DIVISOR)) u_clk_enable (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .tick_o   (tick)
  );

  seq_state_e       state_q, state_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             sensor_start_q, pid_start_q, pwm_update_q, busy_q;
  logic             timeout_c;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_W-1:0] wait_q;
  logic              in_wait_c;
  logic              flag_q;

  assign in_wait_c = (state_q == ST_SENSE_WAIT) || (state_q == ST_PID_WAIT);

  // A done pulse in the expiring cycle still wins over the timeout
  assign timeout_c = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) &&
                     (((state_q == ST_SENSE_WAIT) && !seq_if.sensor_done) ||
                      ((state_q == ST_PID_WAIT)   && !seq_if.pid_done));

  // Wait counter restarts on every state change; sticky flag set on expiry
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wait_q <= '0;
      flag_q <= 1'b0;
    end else begin
      wait_q <= (in_wait_c && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
      if (timeout_c)            flag_q <= 1'b1;
      else if (seq_if.clear_in) flag_q <= 1'b0;
    end
  end

  assign seq_if.timeout_flag = flag_q;
`else
  assign timeout_c           = 1'b0;
  assign seq_if.timeout_flag = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (tick && seq_if.enable_in) state_d = ST_SENSE_REQ;
      ST_SENSE_REQ:  state_d = ST_SENSE_WAIT;
      ST_SENSE_WAIT: begin
        if (seq_if.sensor_done) state_d = ST_PID_REQ;
        else if (timeout_c)     state_d = ST_IDLE;
      end
      ST_PID_REQ:    state_d = ST_PID_WAIT;
      ST_PID_WAIT: begin
        if (seq_if.pid_done)    state_d = ST_UPDATE;
        else if (timeout_c)     state_d = ST_IDLE;
      end
      ST_UPDATE:     state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Clear first, then count a dropped tick, so clear+overrun yields 1
  always_comb begin
    ovr_d = seq_if.clear_in ? '0 : ovr_q;
    if (tick && (state_q != ST_IDLE)) ovr_d = sat_inc(ovr_d);
  end

  // State and Moore outputs registered together from the next state
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= ST_IDLE;
      ovr_q          <= '0;
      sensor_start_q <= 1'b0;
      pid_start_q    <= 1'b0;
      pwm_update_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ovr_q          <= ovr_d;
      sensor_start_q <= (state_d == ST_SENSE_REQ);
      pid_start_q    <= (state_d == ST_PID_REQ);
      pwm_update_q   <= (state_d == ST_UPDATE);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign seq_if.sensor_start = sensor_start_q;
  assign seq_if.pid_start    = pid_start_q;
  assign seq_if.pwm_update   = pwm_update_q;
  assign seq_if.busy         = busy_q;
  assign seq_if.overrun_cnt  = ovr_q;
  assign seq_if.state_out    = state_q;

endmodule

// File: doc/pid_loop_sequencer.md
PID_LOOP_SEQUENCER -- requirements
Module: pid_loop_sequencer

Interface
REQ-001 SHALL have parameter DIVISOR, default 1249999: loop tick period minus one, in clk_in cycles (100 Hz at 125 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 125000: maximum wait for sensor_done or pid_done (1 ms).
REQ-003 SHALL have ports, one per line:
- clk_in  input  1  system clock, 125 MHz.
- reset_in  input  1  reset, asynchronous, active-high.
- enable_in  input  1  run enable; ticks are ignored while low.
- clear_in  input  1  one-cycle pulse; clears the status outputs.
- sensor_done  input  1  one-cycle pulse; sensor sample ready.
- pid_done  input  1  one-cycle pulse; PID result ready.
- sensor_start  output  1  one-cycle pulse; start sensor acquisition.
- pid_start  output  1  one-cycle pulse; start PID compute.
- pwm_update  output  1  one-cycle pulse; latch the new duty into the PWM.
- busy  output  1  high whenever state != IDLE.
- overrun_cnt  output  8  saturating count of dropped ticks.
- timeout_flag  output  1  sticky; a wait state timed out.
- state_out  output  3  current state encoding, for debug.

Function
REQ-004 SHALL generate an internal tick pulse once every DIVISOR+1 cycles; the tick counter free-runs from reset.
REQ-005 SHALL implement the states IDLE=0, SENSE_REQ=1, SENSE_WAIT=2, PID_REQ=3, PID_WAIT=4, UPDATE=5.
REQ-006 SHALL transition IDLE->SENSE_REQ on the cycle after a tick when enable_in=1 on the tick cycle.
REQ-007 SHALL assert sensor_start for exactly the one cycle spent in SENSE_REQ, then go to SENSE_WAIT.
REQ-008 SHALL go SENSE_WAIT->PID_REQ on the cycle after sensor_done=1; sensor_done SHALL be ignored in all other states.
REQ-009 SHALL assert pid_start for exactly the one cycle spent in PID_REQ, then go to PID_WAIT.
REQ-010 SHALL go PID_WAIT->UPDATE on the cycle after pid_done=1; pid_done SHALL be ignored in all other states.
REQ-011 SHALL assert pwm_update for exactly the one cycle spent in UPDATE, then return to IDLE; tick to pwm_update is therefore at least 5 cycles.
REQ-012 SHALL drive all control outputs as registered Moore outputs decoded from state.
REQ-013 SHALL, on a tick while state != IDLE, drop the tick and increment overrun_cnt, saturating at 255.
REQ-014 SHALL, on a tick in IDLE with enable_in=0, ignore the tick without counting it.
REQ-015 SHALL, on clear_in=1, zero overrun_cnt and timeout_flag; if an overrun occurs in the same cycle, the result SHALL be overrun_cnt=1.
REQ-016 SHALL leave a sequence already in progress unaffected when enable_in is deasserted; the current sequence SHALL complete.

Reset
REQ-017 SHALL, while reset_in=1, asynchronously force state=IDLE, tick counter=0, wait counter=0, all pulses=0, busy=0, overrun_cnt=0 and timeout_flag=0.
REQ-018 SHALL treat reset mid-sequence as an abort with no pwm_update; the first tick after release SHALL occur DIVISOR+1 cycles later.

Configuration
REQ-019 SHALL, when SEQ_TIMEOUT_EN is defined, count cycles in SENSE_WAIT and PID_WAIT; on reaching TIMEOUT_CYCLES it SHALL set timeout_flag and go to IDLE without pwm_update.
REQ-020 SHALL, without SEQ_TIMEOUT_EN, wait indefinitely; timeout_flag SHALL be tied to 0 and no wait counter SHALL be synthesized.

Structure
REQ-021 SHALL place the state enum typedef (3-bit) and the overrun counter width constant in the shared package pid_pkg.
REQ-022 SHALL generate the tick with one instance of the existing clk_enable sub-module (clk_in, reset_in, DIVISOR passed through).

Verification (DIVISOR=9, TIMEOUT_CYCLES=20)
REQ-023 Normal loop: enable_in=1, sensor_done 3 cycles after sensor_start, pid_done 2 cycles after pid_start -> exactly one pulse each of sensor_start, pid_start and pwm_update per 10-cycle tick; overrun_cnt=0.
REQ-024 Overrun: sensor_done withheld for 25 cycles, macro undefined -> overrun_cnt=2 and busy=1 throughout; pwm_update follows the late done pulses.
REQ-025 Timeout with SEQ_TIMEOUT_EN defined: pid_done never arrives -> timeout_flag=1 and state=IDLE 20 cycles after entering PID_WAIT; no pwm_update; the next tick restarts the sequence.
REQ-026 Saturation and clear: hold PID_WAIT for 300 ticks -> overrun_cnt=255; clear_in coincident with a tick -> overrun_cnt=1.
REQ-027 Async reset in PID_WAIT: assert reset_in between clock edges -> state=0 and all outputs 0 immediately; first sensor_start occurs 11 cycles after reset release.
REQ-028 Gating: enable_in=0 for 5 ticks -> no sensor_start and overrun_cnt stays 0.
